// File: rtl/taus_multi.sv
// N_CH lock-stepped combined-Tausworthe generators (taus113 or taus88 at runtime),
// seeded through a per-lane LCG, with warm-up and a valid/ready sample port.
module taus_multi #(
  parameter int          N_CH        = 4,
  parameter int          WARMUP      = 10,
  parameter logic [31:0] SEED_RST    = 32'h1234_5678,
  parameter logic [31:0] LANE_STRIDE = 32'h9E37_79B9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        seed,
  input  logic               re_seed,
  input  logic               mode,
  output logic               busy,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic [N_CH*32-1:0] rnd
);

  typedef enum logic [1:0] {S_SEED, S_WARM, S_LOAD, S_RUN} state_t;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP > 0 ? WARMUP - 1 : 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] x_q   [N_CH];
  logic [31:0] x_d   [N_CH];
  logic [31:0] z_q   [N_CH][4];
  logic [31:0] z_d   [N_CH][4];
  logic [31:0] rnd_q [N_CH];
  logic [31:0] rnd_d [N_CH];

  logic [31:0] lcg_w  [N_CH];
  logic [31:0] step_w [N_CH][4];
  logic [31:0] comb_w [N_CH];

  // One Tausworthe component step; taus88 has no fourth component, which stays 0.
  function automatic logic [31:0] step(input logic [31:0] z, input logic [1:0] k, input logic md);
    logic [31:0] r;
    r = '0;
    case ({md, k})
      3'b000:  r = ((z & 32'hFFFF_FFFE) << 18) ^ (((z << 6)  ^ z) >> 13);
      3'b001:  r = ((z & 32'hFFFF_FFF8) << 2)  ^ (((z << 2)  ^ z) >> 27);
      3'b010:  r = ((z & 32'hFFFF_FFF0) << 7)  ^ (((z << 13) ^ z) >> 21);
      3'b011:  r = ((z & 32'hFFFF_FF80) << 13) ^ (((z << 3)  ^ z) >> 12);
      3'b100:  r = ((z & 32'hFFFF_FFFE) << 12) ^ (((z << 13) ^ z) >> 19);
      3'b101:  r = ((z & 32'hFFFF_FFF8) << 4)  ^ (((z << 2)  ^ z) >> 25);
      3'b110:  r = ((z & 32'hFFFF_FFF0) << 17) ^ (((z << 3)  ^ z) >> 11);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Components below their minimum would degenerate, so they are lifted past it.
  function automatic logic [31:0] fixup(input logic [31:0] z, input logic [1:0] k);
    logic [31:0] mn;
    case (k)
      2'd0:    mn = 32'd2;
      2'd1:    mn = 32'd8;
      2'd2:    mn = 32'd16;
      default: mn = 32'd128;
    endcase
    return (z < mn) ? z + mn : z;
  endfunction

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    assign lcg_w[gi] = x_q[gi] * 32'd69069 + 32'd1;
    for (genvar gk = 0; gk < 4; gk++) begin : g_comp
      assign step_w[gi][gk] = step(z_q[gi][gk], 2'(gk), mode_q);
    end
    assign comb_w[gi] = step_w[gi][0] ^ step_w[gi][1] ^ step_w[gi][2] ^ step_w[gi][3];
    assign rnd[32*gi +: 32] = rnd_q[gi];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    x_d     = x_q;
    z_d     = z_q;
    rnd_d   = rnd_q;
    if (re_seed) begin
      state_d = S_SEED;
      cnt_d   = '0;
      mode_d  = mode;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        x_d[i] = seed + 32'(i) * LANE_STRIDE;
        for (int k = 0; k < 4; k++) z_d[i][k] = '0;
      end
    end else begin
      case (state_q)
        S_SEED: begin
          for (int i = 0; i < N_CH; i++) begin
            x_d[i]              = lcg_w[i];
            z_d[i][cnt_q[1:0]]  = fixup(lcg_w[i], cnt_q[1:0]);
          end
          if (cnt_q == (mode_q ? 16'd2 : 16'd3)) begin
            cnt_d   = '0;
            state_d = (WARMUP == 0) ? S_LOAD : S_WARM;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_WARM: begin
          z_d = step_w;
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_LOAD: begin
          z_d     = step_w;
          rnd_d   = comb_w;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_RUN;
        end
        default: begin
          if (valid_q && rnd_ready) begin
            z_d   = step_w;
            rnd_d = comb_w;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SEED;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        x_q[i]   <= SEED_RST + 32'(i) * LANE_STRIDE;
        rnd_q[i] <= '0;
        for (int k = 0; k < 4; k++) z_q[i][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      z_q     <= z_d;
      rnd_q   <= rnd_d;
    end
  end

  assign busy      = busy_q;
  assign rnd_valid = valid_q;

endmodule
